// File: rtl/tof_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tof_i2c_arbiter
//   Shares a single I2C master between NREQ ToF sensor sequencers. Only one
//   register transaction is in flight at a time. A round-robin pointer picks
//   the winner among the active requests, and the winner's fields are frozen
//   onto the master interface. Completion status and read data are returned
//   to the winner only, as a one-cycle req_done pulse.
//
//   Optional feature macro: TOF_ARB_TIMEOUT_EN
//     When it is defined, a 15-bit watchdog ends a BUSY phase that lasts
//     TIMEOUT_CYCLES cycles. That transaction completes with req_error=1 and
//     req_rdata=0.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   req_start[NREQ]      per-requester request, held until its req_done
//   req_addr[NREQ*16]    register address, requester i at [16*i+:16]
//   req_wdata[NREQ*8]    write data, requester i at [8*i+:8]
//   req_is_read[NREQ]    1 = read transaction
//   req_nbytes[NREQ*10]  byte count, requester i at [10*i+:10]
//   req_done[NREQ]       one-hot completion pulse (one cycle)
//   req_error            valid with req_done: transaction failed
//   req_rdata[16]        valid with req_done: data captured from the master
//   m_start              to master, held until m_ready / m_error
//   m_register_address, m_i2c_data, m_is_read, m_nb_of_bytes
//                        frozen fields of the granted requester
//   m_sel[IDXW]          granted requester index
//   m_ready, m_error     master completion / failure
//   m_rdata[16]          master read data
//   busy                 high in BUSY and DONE
// ---------------------------------------------------------------------------
module tof_i2c_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned IDXW           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_start,
  input  logic [NREQ*16-1:0]   req_addr,
  input  logic [NREQ*8-1:0]    req_wdata,
  input  logic [NREQ-1:0]      req_is_read,
  input  logic [NREQ*10-1:0]   req_nbytes,
  output logic [NREQ-1:0]      req_done,
  output logic                 req_error,
  output logic [15:0]          req_rdata,
  output logic                 m_start,
  output logic [15:0]          m_register_address,
  output logic [7:0]           m_i2c_data,
  output logic                 m_is_read,
  output logic [9:0]           m_nb_of_bytes,
  output logic [IDXW-1:0]      m_sel,
  input  logic                 m_ready,
  input  logic                 m_error,
  input  logic [15:0]          m_rdata,
  output logic                 busy
);

  // Elaboration-time sanity check of the configuration.
  localparam bit CFG_OK = (NREQ >= 2) && (NREQ <= 8) &&
                          (NREQ <= (1 << IDXW)) &&
                          (TIMEOUT_CYCLES >= 2) && (TIMEOUT_CYCLES <= 32768);
  if (!CFG_OK) begin : g_bad_cfg
    $error("tof_i2c_arbiter: unsupported NREQ/IDXW/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  state_e            state_q;
  logic [IDXW-1:0]   rr_ptr_q;
  logic [IDXW-1:0]   sel_q;
  logic              start_q;
  logic              busy_q;
  logic [15:0]       addr_q;
  logic [7:0]        wdata_q;
  logic              is_read_q;
  logic [9:0]        nbytes_q;
  logic [NREQ-1:0]   done_q;
  logic              error_q;
  logic [15:0]       rdata_q;

  // -------------------------------------------------------------------------
  // Round-robin winner search: the first active request at or after rr_ptr_q,
  // wrapping modulo NREQ.
  // -------------------------------------------------------------------------
  logic              win_vld_d;
  logic [IDXW-1:0]   win_idx_d;
  logic [IDXW-1:0]   cand_idx;
  int unsigned       cand;

  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NREQ;
      cand_idx = IDXW'(cand);
      if (!win_vld_d && req_start[cand_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand_idx;
      end
    end
  end

  logic [IDXW-1:0] rr_next_d;
  assign rr_next_d = (sel_q == IDXW'(NREQ - 1)) ? '0 : sel_q + 1'b1;

  // -------------------------------------------------------------------------
  // Watchdog (optional). It clears when BUSY is entered and counts BUSY
  // cycles. The timeout is hit on the TIMEOUT_CYCLES-th BUSY clock edge.
  // -------------------------------------------------------------------------
  logic timeout;

`ifdef TOF_ARB_TIMEOUT_EN
  localparam logic [14:0] WD_LAST = 15'(TIMEOUT_CYCLES - 1);

  logic [14:0] wd_q;

  assign timeout = (state_q == ST_BUSY) && (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
    end else if (state_q == ST_IDLE) begin
      wd_q <= '0;
    end else if (state_q == ST_BUSY && !timeout) begin
      wd_q <= wd_q + 15'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Arbitration FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_read_q <= 1'b0;
      nbytes_q  <= '0;
      done_q    <= '0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_vld_d) begin
            sel_q     <= win_idx_d;
            addr_q    <= req_addr[16*win_idx_d +: 16];
            wdata_q   <= req_wdata[8*win_idx_d +: 8];
            is_read_q <= req_is_read[win_idx_d];
            nbytes_q  <= req_nbytes[10*win_idx_d +: 10];
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          // m_error outranks m_ready. m_ready outranks a simultaneous
          // timeout. Only a pure timeout returns zero read data.
          if (m_ready || m_error || timeout) begin
            start_q <= 1'b0;
            error_q <= m_error || !m_ready;
            rdata_q <= (m_ready || m_error) ? m_rdata : 16'h0000;
            done_q  <= NREQ'(1) << sel_q;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q   <= '0;
          error_q  <= 1'b0;
          rdata_q  <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= rr_next_d;
          state_q  <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_start            = start_q;
  assign busy               = busy_q;
  assign m_sel              = sel_q;
  assign m_register_address = addr_q;
  assign m_i2c_data         = wdata_q;
  assign m_is_read          = is_read_q;
  assign m_nb_of_bytes      = nbytes_q;
  assign req_done           = done_q;
  assign req_error          = error_q;
  assign req_rdata          = rdata_q;

endmodule

// File: tb/tb_tof_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tof_i2c_arbiter
//   Directed bench for tof_i2c_arbiter (NREQ=4). Inputs are driven and
//   outputs are sampled on the falling clock edge, and the design acts on
//   the rising edge. The timeout scenario runs only when
//   TOF_ARB_TIMEOUT_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_tof_i2c_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDXW = 2;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_start;
  logic [NREQ*16-1:0]   req_addr;
  logic [NREQ*8-1:0]    req_wdata;
  logic [NREQ-1:0]      req_is_read;
  logic [NREQ*10-1:0]   req_nbytes;
  logic [NREQ-1:0]      req_done;
  logic                 req_error;
  logic [15:0]          req_rdata;
  logic                 m_start;
  logic [15:0]          m_register_address;
  logic [7:0]           m_i2c_data;
  logic                 m_is_read;
  logic [9:0]           m_nb_of_bytes;
  logic [IDXW-1:0]      m_sel;
  logic                 m_ready;
  logic                 m_error;
  logic [15:0]          m_rdata;
  logic                 busy;

  int unsigned total;
  int unsigned bad;

  // Per-requester transaction fields
  logic [15:0] addr_tab   [NREQ] = '{16'h1000, 16'h0000, 16'h7FFF, 16'hABCD};
  logic [7:0]  wdata_tab  [NREQ] = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
  logic        read_tab   [NREQ] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [9:0]  nbytes_tab [NREQ] = '{10'd1, 10'd2, 10'd3, 10'h3FF};

  tof_i2c_arbiter #(
    .NREQ           (NREQ),
    .IDXW           (IDXW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_start          (req_start),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .req_is_read        (req_is_read),
    .req_nbytes         (req_nbytes),
    .req_done           (req_done),
    .req_error          (req_error),
    .req_rdata          (req_rdata),
    .m_start            (m_start),
    .m_register_address (m_register_address),
    .m_i2c_data         (m_i2c_data),
    .m_is_read          (m_is_read),
    .m_nb_of_bytes      (m_nb_of_bytes),
    .m_sel              (m_sel),
    .m_ready            (m_ready),
    .m_error            (m_error),
    .m_rdata            (m_rdata),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_fields();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[16*i +: 16]   = addr_tab[i];
      req_wdata[8*i +: 8]    = wdata_tab[i];
      req_is_read[i]         = read_tab[i];
      req_nbytes[10*i +: 10] = nbytes_tab[i];
    end
  endtask

  // Waits (bounded) for m_start. Checks the number of falling edges it
  // took, and checks the granted index and the fields presented to the master.
  task automatic wait_grant(input int unsigned exp_sel, input int exp_wait);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_start !== 1'b1 && n < 10);
    chk("grant_wait", n, exp_wait);
    chk("grant_m_start", m_start, 1);
    chk("grant_busy", busy, 1);
    chk("grant_m_sel", m_sel, exp_sel);
    chk("grant_addr", m_register_address, addr_tab[exp_sel]);
    chk("grant_wdata", m_i2c_data, wdata_tab[exp_sel]);
    chk("grant_is_read", m_is_read, read_tab[exp_sel]);
    chk("grant_nbytes", m_nb_of_bytes, nbytes_tab[exp_sel]);
  endtask

  // Holds the master busy for lat sampled cycles, then completes. Checks
  // the DONE pulse and the return to IDLE. Drop is applied on the DONE cycle.
  task automatic serve(input int lat, input logic rdy, input logic err,
                       input logic [15:0] rd, input logic [3:0] exp_done,
                       input logic exp_err, input logic [15:0] exp_rd,
                       input logic [3:0] drop);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk("hold_m_start", m_start, 1);
      chk("hold_no_done", req_done, 0);
    end
    m_ready = rdy;
    m_error = err;
    m_rdata = rd;
    @(negedge clk);
    m_ready = 1'b0;
    m_error = 1'b0;
    m_rdata = 16'hDEAD;
    chk("done_onehot", req_done, exp_done);
    chk("done_error", req_error, exp_err);
    chk("done_rdata", req_rdata, exp_rd);
    chk("done_m_start", m_start, 0);
    chk("done_busy", busy, 1);
    req_start = req_start & ~drop;
    @(negedge clk);
    chk("idle_done_clr", req_done, 0);
    chk("idle_error_clr", req_error, 0);
    chk("idle_rdata_clr", req_rdata, 0);
    chk("idle_busy", busy, 0);
    chk("idle_m_start", m_start, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    req_start   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    req_is_read = '0;
    req_nbytes  = '0;
    m_ready     = 1'b0;
    m_error     = 1'b0;
    m_rdata     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m_start", m_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_sel", m_sel, 0);
    chk("rst_done", req_done, 0);
    chk("rst_error", req_error, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_addr", m_register_address, 0);
    chk("rst_nbytes", m_nb_of_bytes, 0);
    reset = 1'b0;
    load_fields();
    @(negedge clk);
    chk("idle_no_start", m_start, 0);

    // Contention: all four requests held, so the grants rotate 0,1,2,3,0.
    // Each m_start follows exactly two low cycles (DONE, IDLE).
    req_start = 4'b1111;
    wait_grant(0, 1);
    serve(5, 1'b1, 1'b0, 16'h1234, 4'b0001, 1'b0, 16'h1234, 4'b0000);
    wait_grant(1, 1);
    serve(5, 1'b1, 1'b0, 16'h1111, 4'b0010, 1'b0, 16'h1111, 4'b0000);
    wait_grant(2, 1);
    serve(5, 1'b1, 1'b0, 16'h2222, 4'b0100, 1'b0, 16'h2222, 4'b0000);
    wait_grant(3, 1);
    serve(5, 1'b1, 1'b0, 16'h3333, 4'b1000, 1'b0, 16'h3333, 4'b0000);
    wait_grant(0, 1);
    serve(5, 1'b1, 1'b0, 16'h4444, 4'b0001, 1'b0, 16'h4444, 4'b1111);
    @(negedge clk);
    chk("contention_quiet", m_start, 0);
    // rr_ptr is now 1

    // Single write request from requester 2. Input changes during BUSY
    // are ignored.
    req_start = 4'b0100;
    wait_grant(2, 1);
    req_addr[2*16 +: 16] = 16'h1111;
    req_is_read[2]       = 1'b1;
    @(negedge clk);
    chk("frozen_addr", m_register_address, 16'h7FFF);
    chk("frozen_is_read", m_is_read, 0);
    load_fields();
    serve(9, 1'b1, 1'b0, 16'h0000, 4'b0100, 1'b0, 16'h0000, 4'b0100);
    // rr_ptr is now 3

    // Read path: requester 1 gets back F002
    req_start = 4'b0010;
    wait_grant(1, 1);
    serve(3, 1'b1, 1'b0, 16'hF002, 4'b0010, 1'b0, 16'hF002, 4'b0010);
    // rr_ptr is now 2

    // Error wins over ready. The pointer advances past 3, so 0 comes next.
    req_start = 4'b1001;
    wait_grant(3, 1);
    serve(2, 1'b1, 1'b1, 16'hBEEF, 4'b1000, 1'b0 | 1'b1, 16'hBEEF, 4'b0000);
    wait_grant(0, 1);
    serve(4, 1'b0, 1'b1, 16'h00C3, 4'b0001, 1'b1, 16'h00C3, 4'b1001);
    // rr_ptr is now 1

    // Reset three cycles after m_start
    req_start = 4'b0100;
    wait_grant(2, 1);
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    req_start = 4'b0000;
    @(negedge clk);
    chk("rstbusy_m_start", m_start, 0);
    chk("rstbusy_busy", busy, 0);
    chk("rstbusy_m_sel", m_sel, 0);
    chk("rstbusy_done", req_done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstbusy_no_done", req_done, 0);
    // From rr_ptr=0 the search picks requester 0. A stale pointer of 1 would pick 2.
    req_start = 4'b0101;
    wait_grant(0, 1);
    serve(3, 1'b1, 1'b0, 16'h5A5A, 4'b0001, 1'b0, 16'h5A5A, 4'b0101);
    // rr_ptr is now 1

`ifdef TOF_ARB_TIMEOUT_EN
    // The watchdog (TIMEOUT_CYCLES=16) fires 16 cycles after m_start rose.
    begin
      int n;
      req_start = 4'b1000;
      wait_grant(3, 1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (req_done === 4'b0000 && n < 40);
      chk("to_latency", n, 16);
      chk("to_done", req_done, 4'b1000);
      chk("to_error", req_error, 1);
      chk("to_rdata", req_rdata, 0);
      chk("to_m_start", m_start, 0);
      req_start = 4'b0000;
      @(negedge clk);
      chk("to_done_clr", req_done, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
